imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory fetch path: a byte-stream loader that fills a word-addressed instruction RAM, which the PC fetch logic then reads.
- Accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit RISC-V instructions.
- Writes words sequentially from byte address 0x00 and serves a combinational fetch port indexed by the 8-bit PC.
- Holds the core off (busy, NOP fetch) while a load is in progress.

Parameters:
- ADDR_W, 8, byte-address width of fetch port (matches PC width).
- DEPTH, 64, number of 32-bit words; must equal 2**(ADDR_W-2).
- NOP_WORD, 32'h00000013, value returned for unwritten words or while busy (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  begin a new load; sampled only in IDLE or DONE.
- in_valid  input  1  in_data valid.
- in_data  input  8  program byte, little-endian within each word.
- in_last  input  1  marks final byte of the image; qualified by in_valid.
- in_ready  output  1  loader accepts a byte this cycle.
- fetch_addr  input  ADDR_W  byte address from PC; bits [1:0] ignored.
- fetch_instr  output  32  instruction at fetch_addr (combinational).
- busy  output  1  high in LOAD.
- done  output  1  high in DONE until next load_start or rst.
- err  output  1  sticky per load: partial final word or overflow.
- word_count  output  $clog2(DEPTH)+1  number of words written this load.

Behaviour:
- Reset: state=IDLE, in_ready=0, busy=0, done=0, err=0, word_count=0, byte_idx=0, assembly reg=0, all per-word valid bits cleared. RAM contents are not cleared; valid bits gate them.
- States: IDLE, LOAD, DONE.
- IDLE/DONE + load_start -> LOAD next cycle. On entry: clear word_count, byte_idx, err, done, and all valid bits.
- LOAD: in_ready = (word_count < DEPTH). A byte is accepted when in_valid && in_ready.
  - Accepted byte goes into assembly bits [8*byte_idx +: 8]; byte_idx increments mod 4.
  - On the 4th byte (byte_idx==3), on the same edge: mem[word_count] <= {in_data, asm[23:0]}, valid[word_count] <= 1, word_count++, byte_idx <= 0.
  - in_last with byte_idx==3: normal final write, then -> DONE.
  - in_last with byte_idx<3: write word with the unfilled upper bytes zero, set valid, word_count++, err=1, -> DONE.
  - Overflow: if word_count==DEPTH while in LOAD, in_ready=0; next cycle -> DONE with err=1. Excess bytes are never accepted.
- load_start while in LOAD is ignored.
- fetch_instr:
  - busy=1 -> NOP_WORD.
  - Otherwise valid[fetch_addr[ADDR_W-1:2]] ? mem[that word] : NOP_WORD.
- Latency: a word written on edge N is visible on fetch_instr after edge N once busy drops. Fetch read is zero-latency.
- rst during LOAD: immediate return to IDLE, all valid bits cleared. The partial image is discarded (fetch returns NOP).
- A new load after DONE invalidates the previous image at LOAD entry.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - Adds output chk_sum[7:0]: the mod-256 sum of every accepted byte (including in_last), cleared at LOAD entry and on rst.
  - Adds input chk_expect[7:0], compared on the DONE transition; mismatch sets err=1.
- Not defined: neither port exists; err reflects only partial-word and overflow conditions.

Decomposition:
- Shared package imem_pkg: state enum (IDLE/LOAD/DONE), NOP_WORD, DEPTH/ADDR_W defaults, word-index width constant.
- One sub-module, imem_byte_packer: byte_idx counter plus assembly register, emitting word_valid/word_data. The top module holds the FSM, RAM, valid bits and fetch mux.

Test Plan:
- Reset, then fetch_addr=0x04 -> fetch_instr=0x00000013. Checks: busy=0, done=0, word_count=0.
- Load bytes 93 01 F0 00 13 02 70 00 (last on 8th) -> done=1, err=0, word_count=2; fetch 0x00=0x00f00193, 0x04=0x00700213, 0x08=0x00000013, 0x05 (misaligned)=0x00700213.
- Same stream with in_valid gaps and in_last on byte 6 -> word1=0x00000213, err=1, word_count=2.
- Stream 257 bytes with no in_last -> after 256 bytes in_ready=0, DONE, err=1, word_count=64; byte 257 never accepted.
- Assert rst after 5 bytes, then fetch 0x00 -> 0x00000013, state IDLE; a reload then succeeds.
- With IMEM_LOADER_CHECKSUM_EN: load 93 01 F0 00 with chk_expect=0x84 -> err=0, chk_sum=0x84; repeat with chk_expect=0x85 -> err=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// default geometry and the NOP instruction used for empty/blocked fetches.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          DEFAULT_ADDR_W = 8;
  localparam int          DEFAULT_DEPTH  = 64;
  localparam int          WORD_IDX_W     = DEFAULT_ADDR_W - 2;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD_C     = 32'h0000_0013;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word packer. Collects accepted bytes into an
// assembly register and presents the finished word combinationally on the
// edge that completes it (4th byte, or an early final byte with the unfilled
// upper bytes zeroed).
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic        word_valid_o,
  output logic [31:0] word_data_o,
  output logic [1:0]  byte_idx_o
);

  logic [1:0]  byte_idx_q;
  logic [31:0] asm_q;

  // A word leaves the packer on the 4th byte or on the image's final byte.
  assign word_valid_o = accept_i && ((byte_idx_q == 2'd3) || last_i);
  assign byte_idx_o   = byte_idx_q;

  // Lanes below the current index come from the assembly register, the
  // current lane takes the incoming byte, lanes above are zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_data_o[8*gi +: 8] = (byte_idx_q > 2'(gi))  ? asm_q[8*gi +: 8] :
                                    (byte_idx_q == 2'(gi)) ? data_i : 8'h00;
  end

  // Byte index and assembly register; cleared after each emitted word so
  // unfilled lanes of a short final word read as zero.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      byte_idx_q <= 2'd0;
      asm_q      <= '0;
    end else if (accept_i) begin
      if (word_valid_o) begin
        byte_idx_q <= 2'd0;
        asm_q      <= '0;
      end else begin
        asm_q[{byte_idx_q, 3'b000} +: 8] <= data_i;
        byte_idx_q                       <= byte_idx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: fills a word-addressed instruction RAM from a
// valid/ready byte stream and serves a zero-latency fetch port to the PC.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a running mod-256 byte
// checksum output and an expected-checksum input checked at load completion.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          ADDR_W   = DEFAULT_ADDR_W,
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] NOP_WORD = NOP_WORD_C
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic [31:0]              fetch_instr,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic [7:0]               chk_expect,
  output logic [7:0]               chk_sum,
`endif
  output logic [$clog2(DEPTH):0]   word_count
);

  localparam int             IDX_W     = ADDR_W - 2;
  localparam int             CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  state_t             state_q;
  logic [CNT_W-1:0]   word_count_q;
  logic               err_q;
  logic [DEPTH-1:0]   valid_q;
  logic [31:0]        mem_q [DEPTH];

  logic               in_ready_w;
  logic               accept;
  logic               packer_clear;
  logic               word_valid;
  logic [31:0]        word_data;
  logic [1:0]         byte_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   fetch_idx;
  logic               unused_fetch_lsbs;

  assign in_ready_w   = (state_q == ST_LOAD) && (word_count_q < DEPTH_CNT);
  assign accept       = in_valid && in_ready_w;
  assign packer_clear = (state_q != ST_LOAD) && load_start;
  assign wr_idx       = word_count_q[IDX_W-1:0];

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (packer_clear),
    .accept_i     (accept),
    .data_i       (in_data),
    .last_i       (in_last),
    .word_valid_o (word_valid),
    .word_data_o  (word_data),
    .byte_idx_o   (byte_idx)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  logic [7:0] chk_d;
  assign chk_d   = chk_q + in_data;
  assign chk_sum = chk_q;
`endif

  // Instruction RAM write port; contents are never cleared, valid bits gate them.
  always_ff @(posedge clk) begin
    if (word_valid) begin
      mem_q[wr_idx] <= word_data;
    end
  end

  // Load FSM: word counter, per-word valid bits and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      err_q        <= 1'b0;
      valid_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q        <= 8'h00;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (load_start) begin
            state_q      <= ST_LOAD;
            word_count_q <= '0;
            err_q        <= 1'b0;
            valid_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q        <= 8'h00;
`endif
          end
        end
        ST_LOAD: begin
          if (word_count_q == DEPTH_CNT) begin
            // RAM full without a final byte: the image is too long.
            state_q <= ST_DONE;
            err_q   <= 1'b1;
          end else if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q <= chk_d;
`endif
            if (word_valid) begin
              valid_q[wr_idx] <= 1'b1;
              word_count_q    <= word_count_q + CNT_W'(1);
            end
            if (in_last) begin
              state_q <= ST_DONE;
              if (byte_idx != 2'd3) begin
                err_q <= 1'b1;
              end
`ifdef IMEM_LOADER_CHECKSUM_EN
              if (chk_d != chk_expect) begin
                err_q <= 1'b1;
              end
`endif
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_w;
  assign busy       = (state_q == ST_LOAD);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign word_count = word_count_q;

  // Fetch port: word-aligned, NOP while loading or for words not yet written.
  assign fetch_idx         = fetch_addr[ADDR_W-1:2];
  assign unused_fetch_lsbs = ^fetch_addr[1:0];
  assign fetch_instr       = (!busy && valid_q[fetch_idx]) ? mem_q[fetch_idx] : NOP_WORD;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams checked every
// cycle against a queue/array model of the loader, plus literal expectations.
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  fetch_addr;
  logic [31:0] fetch_instr;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_expect;
  logic [7:0]  chk_sum;
`endif

  always #5 clk = ~clk;

  imem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .busy        (busy),
    .done        (done),
    .err         (err),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .chk_expect  (chk_expect),
    .chk_sum     (chk_sum),
`endif
    .word_count  (word_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;   // 0 idle, 1 loading, 2 finished
  int          m_count;
  bit          m_err;
  logic [31:0] m_mem [64];
  bit          m_valid [64];
  logic [7:0]  m_bytes [$];
  logic [7:0]  m_chk;

  task automatic m_begin();
    m_count = 0;
    m_err   = 1'b0;
    m_chk   = 8'h00;
    m_bytes.delete();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      m_phase = 0;
      m_begin();
    end else if (m_phase != 1) begin
      if (load_start) begin
        m_phase = 1;
        m_begin();
      end
    end else if (m_count == 64) begin
      m_phase = 2;
      m_err   = 1'b1;
    end else if (in_valid) begin
      m_bytes.push_back(in_data);
      m_chk = m_chk + in_data;
      if (m_bytes.size() == 4 || in_last) begin
        w = 32'h0;
        foreach (m_bytes[i]) w[8*i +: 8] = m_bytes[i];
        m_mem[m_count]   = w;
        m_valid[m_count] = 1'b1;
        m_count++;
        if (in_last && m_bytes.size() < 4) m_err = 1'b1;
        m_bytes.delete();
      end
      if (in_last) begin
        m_phase = 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (m_chk != chk_expect) m_err = 1'b1;
`endif
      end
    end
  endtask

  function automatic logic [31:0] m_fetch(input logic [7:0] a);
    if (m_phase == 1) return NOP;
    if (m_valid[a[7:2]]) return m_mem[a[7:2]];
    return NOP;
  endfunction

  initial begin
    m_phase = 0;
    m_begin();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_busy", 32'(busy), 32'(m_phase == 1));
        check("cyc_done", 32'(done), 32'(m_phase == 2));
        check("cyc_err", 32'(err), 32'(m_err));
        check("cyc_word_count", 32'(word_count), m_count);
        check("cyc_in_ready", 32'(in_ready), 32'(m_phase == 1 && m_count < 64));
        check("cyc_fetch", fetch_instr, m_fetch(fetch_addr));
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("cyc_chk_sum", 32'(chk_sum), 32'(m_chk));
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
    fetch_addr = 8'($urandom);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
    bit acc;
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid   = 1'b0;
        load_start = 1'($urandom_range(0, 1));
        step();
      end
    end
    in_valid   = 1'b1;
    in_data    = b;
    in_last    = last;
    load_start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
    n = 0;
    forever begin
      acc = in_ready;
      step();
      n++;
      if (acc) break;
      if (n > 20) begin
        n_checks++;
        $display("FAIL handshake_timeout: got in_ready=0 for %0d cycles expected 1", n);
        break;
      end
    end
    in_valid   = 1'b0;
    in_last    = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic lit_fetch(input string name, input logic [7:0] a, input logic [31:0] exp);
    step();
    fetch_addr = a;
    #1;
    check(name, fetch_instr, exp);
  endtask

  logic [7:0] prog [8] = '{8'h93, 8'h01, 8'hF0, 8'h00, 8'h13, 8'h02, 8'h70, 8'h00};

  initial begin
    int n;
    rst        = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_last    = 1'b0;
    fetch_addr = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_expect = 8'h00;
`endif
    repeat (3) step();
    cmp_en = 1'b1;
    rst    = 1'b0;

    // Reset state
    fetch_addr = 8'h04;
    #1;
    check("rst_fetch", fetch_instr, 32'h0000_0013);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);

    // Two-word program
    start_load();
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7, 1'b0);
    check("prog_done", 32'(done), 32'd1);
    check("prog_err", 32'(err), 32'd0);
    check("prog_word_count", 32'(word_count), 32'd2);
    lit_fetch("prog_fetch0", 8'h00, 32'h00f0_0193);
    lit_fetch("prog_fetch4", 8'h04, 32'h0070_0213);
    lit_fetch("prog_fetch8", 8'h08, 32'h0000_0013);
    lit_fetch("prog_fetch5", 8'h05, 32'h0070_0213);

    // Short final word with valid gaps
    start_load();
    for (int i = 0; i < 6; i++) send_byte(prog[i], i == 5, 1'b1);
    check("short_done", 32'(done), 32'd1);
    check("short_err", 32'(err), 32'd1);
    check("short_word_count", 32'(word_count), 32'd2);
    lit_fetch("short_fetch4", 8'h04, 32'h0000_0213);
    lit_fetch("short_fetch0", 8'h00, 32'h00f0_0193);

    // Overflow: 256 bytes fill the RAM, the 257th is refused
    start_load();
    for (int k = 0; k < 256; k++) send_byte(8'(k * 7 + 3), 1'b0, 1'b0);
    check("ovf_full_ready", 32'(in_ready), 32'd0);
    check("ovf_full_busy", 32'(busy), 32'd1);
    check("ovf_full_count", 32'(word_count), 32'd64);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    step();
    in_valid = 1'b0;
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_word_count", 32'(word_count), 32'd64);
    lit_fetch("ovf_fetch_fc", 8'hFC, 32'hFCF5_EEE7);
    lit_fetch("ovf_fetch_00", 8'h00, 32'h1811_0A03);

    // Reset in the middle of a load, then reload
    start_load();
    for (int i = 0; i < 5; i++) send_byte(prog[i], 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    fetch_addr = 8'h00;
    #1;
    check("midrst_fetch", fetch_instr, 32'h0000_0013);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_word_count", 32'(word_count), 32'd0);
    start_load();
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7, 1'b0);
    check("reload_done", 32'(done), 32'd1);
    check("reload_err", 32'(err), 32'd0);
    lit_fetch("reload_fetch0", 8'h00, 32'h00f0_0193);

    // Randomized images of assorted lengths
    for (int r = 0; r < 12; r++) begin
      start_load();
      n = $urandom_range(1, 48);
      for (int i = 0; i < n; i++) send_byte(8'($urandom), i == n - 1, 1'b1);
      repeat (3) step();
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_expect = 8'h84;
    start_load();
    for (int i = 0; i < 4; i++) send_byte(prog[i], i == 3, 1'b0);
    check("chk_ok_err", 32'(err), 32'd0);
    check("chk_ok_sum", 32'(chk_sum), 32'h84);
    chk_expect = 8'h85;
    start_load();
    for (int i = 0; i < 4; i++) send_byte(prog[i], i == 3, 1'b0);
    check("chk_bad_err", 32'(err), 32'd1);
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
